// File: rtl/mult_pkg.sv
// Shared types and helpers for the pipelined multiply unit.
package mult_pkg;

  // Operation codes as presented on in_op.
  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,  // low word of the product
    OP_MULXSS = 2'd1,  // high word, a signed, b signed
    OP_MULXSU = 2'd2,  // high word, a signed, b unsigned
    OP_MULXUU = 2'd3   // high word, a unsigned, b unsigned
  } mult_op_e;

  // Width of one operand half; operands are split into lo/hi halves.
  function automatic int half_w(input int data_w);
    return data_w / 2;
  endfunction

endpackage

// File: rtl/mult_pp_array.sv
// Four unsigned HALF_W x HALF_W partial-product multipliers with their
// stage-1 output registers. Shaped to map onto dedicated DSP multipliers.
module mult_pp_array
  import mult_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] pp_ll,
  output logic [DATA_W-1:0] pp_lh,
  output logic [DATA_W-1:0] pp_hl,
  output logic [DATA_W-1:0] pp_hh
);

  localparam int HALF_W = half_w(DATA_W);

  // Zero-extended halves so each product is formed at full DATA_W width.
  logic [DATA_W-1:0] a_lo, a_hi, b_lo, b_hi;

  assign a_lo = {{HALF_W{1'b0}}, a[HALF_W-1:0]};
  assign a_hi = {{HALF_W{1'b0}}, a[DATA_W-1:HALF_W]};
  assign b_lo = {{HALF_W{1'b0}}, b[HALF_W-1:0]};
  assign b_hi = {{HALF_W{1'b0}}, b[DATA_W-1:HALF_W]};

  // Register the four partial products whenever the pipeline advances.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    if (reset) begin
      // NOTE: these are individual flops rather than a memory array, so they
      // can be cleared on reset and out_result stays deterministic.
      pp_ll <= '0;
      pp_lh <= '0;
      pp_hl <= '0;
      pp_hh <= '0;
    end else if (en) begin
      pp_ll <= a_lo * b_lo;
      pp_lh <= a_lo * b_hi;
      pp_hl <= a_hi * b_lo;
      pp_hh <= a_hi * b_hi;
    end
  end

endmodule

// File: rtl/mult_pipe_unit.sv
// Elastic three-stage multiplier: S1 partial products, S2 sum and signed
// correction term, S3 word select and correction. Valid/ready on both sides,
// single global advance, bubbles are kept.
module mult_pipe_unit
  import mult_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int HALF_W = half_w(DATA_W);
  localparam int PROD_W = 2 * DATA_W;

  // The whole pipe moves together unless a valid result is being held.
  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // ---------------- S1 ----------------
  logic              s1_valid;
  mult_op_e          s1_op;
  logic [TAG_W-1:0]  s1_tag;
  logic              s1_sign_a, s1_sign_b;
  logic [DATA_W-1:0] s1_a, s1_b;
  logic [DATA_W-1:0] pp_ll, pp_lh, pp_hl, pp_hh;

  mult_pp_array #(.DATA_W(DATA_W)) u_pp (
    .clk   (clk),
    .reset (reset),
    .en    (adv),
    .a     (in_a),
    .b     (in_b),
    .pp_ll (pp_ll),
    .pp_lh (pp_lh),
    .pp_hl (pp_hl),
    .pp_hh (pp_hh)
  );

  // Capture op, tag, operand signs and operands alongside the partial products.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_op     <= OP_MUL;
      s1_tag    <= '0;
      s1_sign_a <= 1'b0;
      s1_sign_b <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_op     <= mult_op_e'(in_op);
      s1_tag    <= in_tag;
      s1_sign_a <= in_a[DATA_W-1];
      s1_sign_b <= in_b[DATA_W-1];
      s1_a      <= in_a;
      s1_b      <= in_b;
    end
  end

  // ---------------- S2 ----------------
  logic [PROD_W-1:0] p_u_next;
  logic [DATA_W-1:0] corr_next;

  // Sum the partial products at full width and form the signed correction.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    p_u_next  = '0;
    corr_next = '0;
    p_u_next  = {{DATA_W{1'b0}}, pp_ll}
              + ({{DATA_W{1'b0}}, pp_lh} << HALF_W)
              + ({{DATA_W{1'b0}}, pp_hl} << HALF_W)
              + ({{DATA_W{1'b0}}, pp_hh} << DATA_W);
    case (s1_op)
      OP_MULXSS: corr_next = (s1_sign_a ? s1_b : '0) + (s1_sign_b ? s1_a : '0);
      OP_MULXSU: corr_next = s1_sign_a ? s1_b : '0;
      default:   corr_next = '0;
    endcase
  end

  logic              s2_valid;
  mult_op_e          s2_op;
  logic [TAG_W-1:0]  s2_tag;
  logic [PROD_W-1:0] s2_p_u;
  logic [DATA_W-1:0] s2_corr;

  // Register the unsigned product and correction term.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_op    <= OP_MUL;
      s2_tag   <= '0;
      s2_p_u   <= '0;
      s2_corr  <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_op    <= s1_op;
      s2_tag   <= s1_tag;
      s2_p_u   <= p_u_next;
      s2_corr  <= corr_next;
    end
  end

  // ---------------- S3 ----------------
  logic [DATA_W-1:0] result_next;

  // Low word needs no correction; high words subtract the signed fix-up.
  always_comb begin
    result_next = '0;
    if (s2_op == OP_MUL) result_next = s2_p_u[DATA_W-1:0];
    else                 result_next = s2_p_u[PROD_W-1:DATA_W] - s2_corr;
  end

  // Output register: result, tag and valid presented to the consumer.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (adv) begin
      out_valid  <= s2_valid;
      out_result <= result_next;
      out_tag    <= s2_tag;
    end
  end

endmodule

// File: tb/tb_mult_pipe_unit.sv
// Directed and scoreboard bench for mult_pipe_unit (DATA_W=32 and DATA_W=16).
module tb_mult_pipe_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b, out_result;
  logic [4:0]  in_tag, out_tag;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [1:0]  in_op16;
  logic [15:0] in_a16, in_b16, out_result16;
  logic [4:0]  in_tag16, out_tag16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_pipe_unit #(.DATA_W(32), .TAG_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  mult_pipe_unit #(.DATA_W(16), .TAG_W(5)) dut16 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_op(in_op16),
    .in_a(in_a16), .in_b(in_b16), .in_tag(in_tag16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .out_result(out_result16), .out_tag(out_tag16)
  );

  // Reference: full 64-bit product with explicit sign extension.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] au, bu, as_, bs, p;
    au  = {32'd0, a};
    bu  = {32'd0, b};
    as_ = {{32{a[31]}}, a};
    bs  = {{32{b[31]}}, b};
    case (op)
      2'd0:    begin p = au * bu;   return p[31:0];  end
      2'd1:    begin p = as_ * bs;  return p[63:32]; end
      2'd2:    begin p = as_ * bu;  return p[63:32]; end
      default: begin p = au * bu;   return p[63:32]; end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
    total++; if (out_result !== 32'd0) begin bad++; $display("FAIL reset_out_result got=%h want=0", out_result); end
    total++; if (out_tag !== 5'd0) begin bad++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
    total++; if (out_valid16 !== 1'b0) begin bad++; $display("FAIL reset_out_valid16 got=%0b want=0", out_valid16); end
    reset = 1'b0;
    tick();
  endtask

  // One op at a time: exact 3-cycle latency and hand-computed results.
  task automatic test_single_ops();
    logic [1:0]  ops  [6] = '{2'd0, 2'd3, 2'd1, 2'd2, 2'd1, 2'd1};
    logic [31:0] av   [6] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'h8000_0000, 32'h8000_0000};
    logic [31:0] bv   [6] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'h8000_0000, 32'h0000_0002};
    logic [31:0] expv [6] = '{32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF,
                              32'h4000_0000, 32'hFFFF_FFFF};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_op = ops[i]; in_a = av[i]; in_b = bv[i]; in_tag = 5'(3 + i);
      tick();
      in_valid = 1'b0;
      tick();
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid vec=%0d got=%0b want=0", i, out_valid); end
      tick();
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid vec=%0d got=%0b want=1", i, out_valid); end
      total++; if (out_result !== expv[i]) begin bad++; $display("FAIL single_result vec=%0d got=%h want=%h", i, out_result, expv[i]); end
      total++; if (out_tag !== 5'(3 + i)) begin bad++; $display("FAIL single_tag vec=%0d got=%0d want=%0d", i, out_tag, 3 + i); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c < 8) begin
        in_valid = 1'b1; in_op = 2'd0; in_a = 32'(c + 1); in_b = 32'(c + 3); in_tag = 5'(c + 10);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid) begin
        total++;
        if (got >= 8 || c != 3 + got || out_result !== 32'((got + 1) * (got + 3)) ||
            out_tag !== 5'(got + 10)) begin
          bad++;
          $display("FAIL b2b_result idx=%0d cyc=%0d got=%h/%0d want=%h/%0d at cyc %0d",
                   got, c, out_result, out_tag, 32'((got + 1) * (got + 3)), got + 10, 3 + got);
        end
        got++;
      end
      tick();
    end
    total++; if (got != 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", got); end
  endtask

  task automatic test_stall();
    logic [1:0]  ops  [3] = '{2'd3, 2'd0, 2'd1};
    logic [31:0] av   [3] = '{32'h0001_0000, 32'd6, 32'hFFFF_FFFE};
    logic [31:0] bv   [3] = '{32'h0001_0000, 32'd7, 32'd3};
    logic [31:0] expv [3] = '{32'h0000_0001, 32'd42, 32'hFFFF_FFFF};
    int got = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_op = ops[i]; in_a = av[i]; in_b = bv[i]; in_tag = 5'(20 + i);
      tick();
    end
    // Oldest op now presented; hold it while upstream keeps offering a fourth.
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'd0; in_a = 32'd9; in_b = 32'd9; in_tag = 5'd31;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready cyc=%0d got=%0b want=0", c, in_ready); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_out_valid cyc=%0d got=%0b want=1", c, out_valid); end
      total++; if (out_result !== expv[0] || out_tag !== 5'd20) begin
        bad++; $display("FAIL stall_hold cyc=%0d got=%h/%0d want=%h/20", c, out_result, out_tag, expv[0]);
      end
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) begin
        total++;
        if (got >= 3 || c != got || out_result !== expv[got] || out_tag !== 5'(20 + got)) begin
          bad++;
          $display("FAIL stall_drain idx=%0d cyc=%0d got=%h/%0d", got, c, out_result, out_tag);
        end
        got++;
      end
      tick();
    end
    total++; if (got != 3) begin bad++; $display("FAIL stall_drain_count got=%0d want=3", got); end
  endtask

  task automatic test_reset_flight();
    int got = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 2'd0; in_a = 32'd3; in_b = 32'd4; in_tag = 5'd7;
    tick();
    in_a = 32'd11; in_b = 32'd2; in_tag = 5'd8;
    tick();
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b1; in_op = 2'd0; in_a = 32'd5; in_b = 32'd5; in_tag = 5'd9;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_flight_valid got=%0b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_flight_in_ready got=%0b want=1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (out_valid) begin
        total++;
        if (c != 3 || out_tag !== 5'd9 || out_result !== 32'd25) begin
          bad++;
          $display("FAIL rst_flight_result cyc=%0d got=%h/%0d want=00000019/9 at cyc 3", c, out_result, out_tag);
        end
        got++;
      end
      tick();
    end
    total++; if (got != 1) begin bad++; $display("FAIL rst_flight_count got=%0d want=1", got); end
  endtask

  task automatic test_scoreboard();
    logic [31:0] exp_res [$];
    logic [4:0]  exp_tag [$];
    logic [31:0] er;
    logic [4:0]  et;
    for (int c = 0; c < 620; c++) begin
      if (c < 600) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_op     = 2'($urandom_range(0, 3));
        in_a      = pick_operand();
        in_b      = pick_operand();
        in_tag    = 5'($urandom_range(0, 31));
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        total++;
        if (exp_res.size() == 0) begin
          bad++; $display("FAIL sb_unexpected cyc=%0d got=%h/%0d", c, out_result, out_tag);
        end else begin
          er = exp_res.pop_front();
          et = exp_tag.pop_front();
          if (out_result !== er || out_tag !== et) begin
            bad++; $display("FAIL sb_result cyc=%0d got=%h/%0d want=%h/%0d", c, out_result, out_tag, er, et);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_res.push_back(ref_mul(in_op, in_a, in_b));
        exp_tag.push_back(in_tag);
      end
      tick();
    end
    total++; if (exp_res.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", exp_res.size()); end
  endtask

  task automatic test_width16();
    logic [1:0]  ops  [4] = '{2'd3, 2'd1, 2'd0, 2'd2};
    logic [15:0] av   [4] = '{16'hFFFF, 16'hFFFF, 16'h1234, 16'h8000};
    logic [15:0] bv   [4] = '{16'hFFFF, 16'hFFFF, 16'h0010, 16'h0002};
    logic [15:0] expv [4] = '{16'hFFFE, 16'h0000, 16'h2340, 16'hFFFF};
    int got = 0;
    out_ready16 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 4) begin
        in_valid16 = 1'b1; in_op16 = ops[c]; in_a16 = av[c]; in_b16 = bv[c]; in_tag16 = 5'(c + 1);
      end else begin
        in_valid16 = 1'b0;
      end
      @(negedge clk);
      if (out_valid16) begin
        total++;
        if (got >= 4 || c != 3 + got || out_result16 !== expv[got] || out_tag16 !== 5'(got + 1)) begin
          bad++;
          $display("FAIL w16_result idx=%0d cyc=%0d got=%h/%0d", got, c, out_result16, out_tag16);
        end
        got++;
      end
      tick();
    end
    total++; if (got != 4) begin bad++; $display("FAIL w16_count got=%0d want=4", got); end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_op = 2'd0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    in_valid16 = 1'b0; in_op16 = 2'd0; in_a16 = '0; in_b16 = '0; in_tag16 = '0; out_ready16 = 1'b1;
    test_reset();
    test_single_ops();
    test_back_to_back();
    test_stall();
    test_reset_flight();
    test_width16();
    test_scoreboard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
